// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator keypad front end.
package calc_pkg;

   typedef enum logic [1:0] {
      S_SCAN,
      S_DEBOUNCE,
      S_HELD,
      S_RELEASE
   } state_t;

   // KEYMAP[row][col]: hex value printed on each key.
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   localparam logic [3:0] ROW_RESET = 4'b1110;

   // Lowest-index low column wins when several keys share the driven row.
   function automatic logic [1:0] first_low(input logic [3:0] c);
      if (!c[0])      return 2'd0;
      else if (!c[1]) return 2'd1;
      else if (!c[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   function automatic logic [1:0] row_index(input logic [3:0] r);
      case (r)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer; resets to all ones (idle for active-low lines).
module sync2 #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   logic [N-1:0] meta;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce; accepted keys shift into a 16-bit entry register.
module keypad_entry
   import calc_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  col,
   input  logic        clr,
   output logic [3:0]  row,
   output logic [15:0] data,
   output logic [3:0]  key_code,
   output logic        key_valid
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic [3:0]    cs;
   logic [SW-1:0] slot;
   state_t        state, state_next;
   logic [3:0]    cand, cand_next;
   logic [CW-1:0] match, match_next;
   logic [CW-1:0] rel, rel_next;
   logic          sample, idle, rotate, accept;
   logic [3:0]    code;

   sync2 #(.N(4)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (col),
      .q     (cs)
   );

   assign sample = (slot == SLOT_LAST);
   assign idle   = &cs;
   assign code   = KEYMAP[row_index(row)][first_low(cs)];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_SCAN;
         slot  <= '0;
         cand  <= '0;
         match <= '0;
         rel   <= '0;
         row   <= ROW_RESET;
      end else begin
         state <= state_next;
         slot  <= sample ? '0 : slot + 1'b1;
         cand  <= cand_next;
         match <= match_next;
         rel   <= rel_next;
         if (rotate)
            row <= {row[2:0], row[3]};
      end
   end

   always_comb begin
      state_next = state;
      cand_next  = cand;
      match_next = match;
      rel_next   = rel;
      rotate     = 1'b0;
      accept     = 1'b0;
      if (sample) begin
         case (state)
            S_SCAN: begin
               if (idle) begin
                  rotate = 1'b1;
               end else begin
                  cand_next  = code;
                  match_next = CNT_ONE;
                  state_next = S_DEBOUNCE;
               end
            end
            S_DEBOUNCE: begin
               if (!idle && code == cand) begin
                  match_next = match + CNT_ONE;
                  if (match_next == CNT_DONE) begin
                     accept     = 1'b1;
                     state_next = S_HELD;
                  end
               end else begin
                  rotate     = 1'b1;
                  state_next = S_SCAN;
               end
            end
            S_HELD: begin
               // Any non-idle pattern (even a different key) keeps us here.
               if (idle) begin
                  rel_next   = CNT_ONE;
                  state_next = S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (idle) begin
                  rel_next = rel + CNT_ONE;
                  if (rel_next == CNT_DONE) begin
                     rotate     = 1'b1;
                     state_next = S_SCAN;
                  end
               end else begin
                  state_next = S_HELD;
               end
            end
            default: state_next = S_SCAN;
         endcase
      end
   end

   // Clear takes priority over a coincident shift; key_code/key_valid still update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
      end else begin
         key_valid <= accept;
         if (accept)
            key_code <= cand;
         if (clr)
            data <= '0;
         else if (accept)
            data <= {data[11:0], cand};
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench: models a physical keypad and tracks expected entry digits.
module tb_keypad_entry;

   localparam int SD = 4;
   localparam int DB = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clr = 1'b0;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [15:0] data;
   logic [3:0]  key_code;
   logic        key_valid;

   logic [15:0] mask = '0;
   int          cyc = 0;
   int          pulses = 0;
   int          exp_pulses = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_data = '0;
   logic [3:0]  km [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

   keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk       (clk),
      .reset     (reset),
      .col       (col),
      .clr       (clr),
      .row       (row),
      .data      (data),
      .key_code  (key_code),
      .key_valid (key_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (reset && key_valid) pulses <= pulses + 1;
   end

   // Keypad matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         if (row[r] == 1'b0)
            for (int c = 0; c < 4; c++)
               if (mask[r*4+c]) col[c] = 1'b0;
   end

   function automatic logic [15:0] key_bit(input logic [3:0] code);
      for (int i = 0; i < 16; i++)
         if (km[i] == code) return 16'(1) << i;
      return '0;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_sample();
      do begin
         @(posedge clk);
         #1;
      end while (cyc % SD != 0);
   endtask

   task automatic wait_row(input logic [3:0] r);
      int n;
      n = 0;
      do begin
         next_sample();
         n++;
      end while (row !== r && n < 8);
      check("row_reach", {12'h0, row}, {12'h0, r});
   endtask

   task automatic wait_pulse(output bit got);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check("pulse_seen", {15'h0, got}, 16'h1);
   endtask

   task automatic expect_accept(input logic [3:0] code);
      exp_data = {exp_data[11:0], code};
      exp_pulses++;
      check("key_code", {12'h0, key_code}, {12'h0, code});
      check("data", data, exp_data);
      @(negedge clk);
      check("pulse_width", {15'h0, key_valid}, 16'h0);
   endtask

   task automatic release_all();
      mask = '0;
      repeat (DB + 2) next_sample();
      check("pulse_count", 16'(pulses), 16'(exp_pulses));
   endtask

   task automatic press(input logic [3:0] code, input int extra);
      bit got;
      mask = key_bit(code);
      wait_pulse(got);
      if (got) expect_accept(code);
      repeat (extra) next_sample();
      release_all();
   endtask

   task automatic clear_entry();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_data = '0;
      check("clr", data, 16'h0000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      logic [3:0] r0;
      logic [3:0] seq [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h7};

      // Reset and idle scanning
      @(posedge clk);
      #1;
      check("rst_row", {12'h0, row}, 16'h000E);
      check("rst_data", data, 16'h0000);
      check("rst_code", {12'h0, key_code}, 16'h0);
      check("rst_valid", {15'h0, key_valid}, 16'h0);
      reset = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         check("idle_row", {12'h0, row}, {12'h0, 4'b1111 ^ (4'b0001 << ((k / SD) % 4))});
      end
      check("idle_pulses", 16'(pulses), 16'h0);
      check("idle_data", data, 16'h0000);

      // Single key "5", then verify scanning resumes
      press(4'h5, DB);
      check("five_data", data, 16'h0005);
      r0 = row;
      next_sample();
      check("scan_resume", {12'h0, row}, {12'h0, r0[2:0], r0[3]});

      // Sequence entry
      clear_entry();
      for (int i = 0; i < 5; i++) press(seq[i], i % 2);
      check("seq_data", data, 16'h23A7);

      // Bounce on "9": two samples, gap, then a real press
      clear_entry();
      wait_row(4'b1011);
      mask = key_bit(4'h9);
      next_sample();
      next_sample();
      mask = '0;
      next_sample();
      check("bounce_nopulse", 16'(pulses), 16'(exp_pulses));
      mask = key_bit(4'h9);
      wait_pulse(got);
      if (got) expect_accept(4'h9);
      release_all();
      check("bounce_data", data, 16'h0009);

      // Second key while first held is ignored
      clear_entry();
      mask = key_bit(4'hD);
      wait_pulse(got);
      if (got) expect_accept(4'hD);
      mask = mask | key_bit(4'h0);
      repeat (4) next_sample();
      check("held_ignore", 16'(pulses), 16'(exp_pulses));
      release_all();
      press(4'h0, 0);
      check("d0_data", data, 16'h00D0);

      // Clear coincident with accept of "F"
      clear_entry();
      for (int i = 1; i <= 4; i++) press(4'(i), 0);
      check("pre_clr_data", data, 16'h1234);
      wait_row(4'b0111);
      mask = key_bit(4'hF);
      next_sample();
      next_sample();
      repeat (SD - 1) begin
         @(posedge clk);
         #1;
      end
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      exp_data = '0;
      exp_pulses++;
      check("clracc_valid", {15'h0, key_valid}, 16'h1);
      check("clracc_code", {12'h0, key_code}, 16'h000F);
      check("clracc_data", data, exp_data);
      release_all();

      // Reset during debounce
      wait_row(4'b1110);
      mask = key_bit(4'h1);
      next_sample();
      next_sample();
      reset = 1'b0;
      mask = '0;
      @(posedge clk);
      #1;
      check("midrst_row", {12'h0, row}, 16'h000E);
      check("midrst_data", data, 16'h0000);
      check("midrst_code", {12'h0, key_code}, 16'h0);
      check("midrst_valid", {15'h0, key_valid}, 16'h0);
      reset = 1'b1;
      exp_data = '0;
      repeat (10 * SD) @(posedge clk);
      #1;
      check("midrst_nopulse", 16'(pulses), 16'(exp_pulses));

      // Randomized key entry against the digit model
      for (int i = 0; i < 8; i++)
         press(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      check("rand_data", data, exp_data);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
